keypad_scanner: RTL and testbench

Scans the calculator's 4x4 matrix keypad and converts presses into debounced single-cycle key events. It drives the column lines, samples the row lines, and classifies each key as digit, operator, clear or equals. It is the transmitting end of the key-event interface consumed by the number-entry and operation control logic: `key_valid` plus `key_code` replace raw keyboard enables with one clean pulse per press.

---
 rtl/keypad_scanner.sv | 196 +++++++++++++++++++
 tb/tb_keypad_scanner.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 matrix keypad and emits one debounced key_valid pulse per press.
// Define KEYPAD_AUTOREPEAT_EN to re-pulse key_valid every REPEAT_CYCLES while the key stays down.
module keypad_scanner #(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_CYCLES   = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows_n,
    output logic [3:0] cols_n,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       is_digit,
    output logic       is_op,
    output logic       is_clear,
    output logic       is_equal,
    output logic       key_held
);

    // One width serves every counter, sized for the largest terminal count.
    localparam int MAX_A = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
    localparam int MAX_CNT = (MAX_A > REPEAT_CYCLES) ? MAX_A : REPEAT_CYCLES;
    localparam int CNT_W = $clog2(MAX_CNT + 1);
    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

    state_t           state, state_next;
    logic [3:0]       sync_stage, rs;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [3:0]       cols_next, cols_rot;
    logic [3:0]       pattern, pattern_next;
    logic [1:0]       row_idx, row_next, col_idx, col_next;
    logic             key_valid_next, key_held_next;
    logic [3:0]       key_code_next;
    logic [3:0]       flags, flags_next;

    assign {is_digit, is_op, is_clear, is_equal} = flags;
    assign cols_rot = {cols_n[2:0], cols_n[3]};

    function automatic logic one_low(input logic [3:0] v);
        return (v == 4'b1110) || (v == 4'b1101) || (v == 4'b1011) || (v == 4'b0111);
    endfunction

    function automatic logic [1:0] low_index(input logic [3:0] v);
        case (v)
            4'b1101: return 2'd1;
            4'b1011: return 2'd2;
            4'b0111: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        case ({row, col})
            4'h0: return 4'h1;  4'h1: return 4'h2;  4'h2: return 4'h3;  4'h3: return 4'hA;
            4'h4: return 4'h4;  4'h5: return 4'h5;  4'h6: return 4'h6;  4'h7: return 4'hB;
            4'h8: return 4'h7;  4'h9: return 4'h8;  4'hA: return 4'h9;  4'hB: return 4'hC;
            4'hC: return 4'hE;  4'hD: return 4'h0;  4'hE: return 4'hF;  default: return 4'hD;
        endcase
    endfunction

    // Flag order matches {is_digit, is_op, is_clear, is_equal}.
    function automatic logic [3:0] classify(input logic [3:0] code);
        return {code <= 4'h9, (code >= 4'hA) && (code <= 4'hD), code == 4'hE, code == 4'hF};
    endfunction

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
    logic [CNT_W-1:0] rep, rep_next;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_stage <= 4'b1111;
            rs         <= 4'b1111;
            state      <= SCAN;
            cnt        <= '0;
            cols_n     <= 4'b1110;
            pattern    <= 4'b1111;
            row_idx    <= '0;
            col_idx    <= '0;
            key_valid  <= 1'b0;
            key_code   <= '0;
            flags      <= '0;
            key_held   <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep        <= '0;
`endif
        end else begin
            sync_stage <= rows_n;
            rs         <= sync_stage;
            state      <= state_next;
            cnt        <= cnt_next;
            cols_n     <= cols_next;
            pattern    <= pattern_next;
            row_idx    <= row_next;
            col_idx    <= col_next;
            key_valid  <= key_valid_next;
            key_code   <= key_code_next;
            flags      <= flags_next;
            key_held   <= key_held_next;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep        <= rep_next;
`endif
        end
    end

    // The shared counter is the dwell timer in SCAN, the press count in DEBOUNCE, the release count in HELD.
    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        cols_next      = cols_n;
        pattern_next   = pattern;
        row_next       = row_idx;
        col_next       = col_idx;
        key_valid_next = 1'b0;
        key_held_next  = key_held;
        key_code_next  = key_code;
        flags_next     = flags;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_next       = rep;
`endif
        case (state)
            SCAN: begin
                if (cnt == SCAN_LAST) begin
                    cnt_next = '0;
                    if (one_low(rs)) begin
                        pattern_next = rs;
                        row_next     = low_index(rs);
                        col_next     = low_index(cols_n);
                        state_next   = DEBOUNCE;
                    end else begin
                        cols_next = cols_rot;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (rs == pattern) begin
                    if (cnt == DEB_LAST) begin
                        key_code_next  = key_map(row_idx, col_idx);
                        flags_next     = classify(key_map(row_idx, col_idx));
                        key_valid_next = 1'b1;
                        key_held_next  = 1'b1;
                        cnt_next       = '0;
                        state_next     = HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
                        rep_next       = '0;
`endif
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end else begin
                    cnt_next   = '0;
                    cols_next  = cols_rot;
                    state_next = SCAN;
                end
            end
            HELD: begin
                if (rs == 4'b1111) begin
                    if (cnt == DEB_LAST) begin
                        key_held_next = 1'b0;
                        cnt_next      = '0;
                        cols_next     = cols_rot;
                        state_next    = SCAN;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end else begin
                    cnt_next = '0;
                end
`ifdef KEYPAD_AUTOREPEAT_EN
                if (rs == pattern) begin
                    if (rep == REP_LAST) begin
                        key_valid_next = 1'b1;
                        rep_next       = '0;
                    end else begin
                        rep_next = rep + 1'b1;
                    end
                end else begin
                    rep_next = '0;
                end
`endif
            end
            default: begin
                cnt_next   = '0;
                state_next = SCAN;
            end
        endcase
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: scoreboard bench for keypad_scanner using a behavioural 4x4 key matrix.
// Expectations follow KEYPAD_AUTOREPEAT_EN when the bench is built with it.
`timescale 1ns/1ps
module tb_keypad_scanner;

    localparam int SCAN_DIV        = 4;
    localparam int DEBOUNCE_CYCLES = 8;
    localparam int REPEAT_CYCLES   = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  rows_n;
    logic [3:0]  cols_n;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        is_digit, is_op, is_clear, is_equal;
    logic        key_held;
    logic [15:0] key_mask = '0;

    typedef struct packed { logic [3:0] code; logic [3:0] flags; } exp_t;
    typedef struct packed { logic [3:0] code; logic [3:0] flags; logic [31:0] cyc; } obs_t;

    exp_t        exp_q[$];
    obs_t        obs_q[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] cyc = '0;

    keypad_scanner #(
        .SCAN_DIV(SCAN_DIV),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_CYCLES(REPEAT_CYCLES)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rows_n(rows_n),
        .cols_n(cols_n),
        .key_valid(key_valid),
        .key_code(key_code),
        .is_digit(is_digit),
        .is_op(is_op),
        .is_clear(is_clear),
        .is_equal(is_equal),
        .key_held(key_held)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // A pressed key pulls its row low only while its column is driven.
    always_comb begin
        rows_n = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (key_mask[r*4+c] && !cols_n[c]) rows_n[r] = 1'b0;
    end

    always @(negedge clk)
        if (key_valid === 1'b1)
            obs_q.push_back(obs_t'{key_code, {is_digit, is_op, is_clear, is_equal}, cyc});

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_and_release(input int r, input int c, input int hold, output bit timed_out);
        int n;
        timed_out = 1'b0;
        key_mask = '0;
        key_mask[r*4+c] = 1'b1;
        n = 0;
        while (key_valid !== 1'b1 && n < 200) begin step(1); n++; end
        if (n >= 200) timed_out = 1'b1;
        step(hold);
        key_mask = '0;
        n = 0;
        while (key_held !== 1'b0 && n < 200) begin step(1); n++; end
        if (n >= 200) timed_out = 1'b1;
        step(4);
    endtask

    task automatic test_reset();
        logic [3:0] exp_cols;
        reset = 1'b1;
        key_mask = '0;
        step(3);
        total++; if (cols_n !== 4'b1110) begin bad++; $display("[TB] FAIL reset_cols: got %b want 1110", cols_n); end
        total++; if (key_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b want 0", key_valid); end
        total++; if (key_code !== 4'h0) begin bad++; $display("[TB] FAIL reset_code: got %h want 0", key_code); end
        total++; if ({is_digit, is_op, is_clear, is_equal} !== 4'b0000) begin
            bad++; $display("[TB] FAIL reset_flags: got %b want 0000", {is_digit, is_op, is_clear, is_equal});
        end
        total++; if (key_held !== 1'b0) begin bad++; $display("[TB] FAIL reset_held: got %b want 0", key_held); end
        reset = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            step(1);
            exp_cols = ~(4'b0001 << ((i / 4) % 4));
            total++;
            if (cols_n !== exp_cols) begin
                bad++; $display("[TB] FAIL scan_cols[%0d]: got %b want %b", i, cols_n, exp_cols);
            end
        end
        total++; if (obs_q.size() != 0) begin bad++; $display("[TB] FAIL idle_pulses: got %0d want 0", obs_q.size()); end
        obs_q.delete();
    endtask

    task automatic test_single_press();
        exp_t e;
        obs_t o;
        reset = 1'b1;
        key_mask = '0;
        key_mask[5] = 1'b1;
        step(3);
        reset = 1'b0;
        exp_q.push_back(exp_t'{4'h5, 4'b1000});
        step(15);
        total++; if (key_valid !== 1'b0) begin bad++; $display("[TB] FAIL press_early: got %b want 0", key_valid); end
        step(1);
        total++; if (key_valid !== 1'b1) begin bad++; $display("[TB] FAIL press_latency: got %b want 1", key_valid); end
        total++; if (key_held !== 1'b1) begin bad++; $display("[TB] FAIL press_held: got %b want 1", key_held); end
        step(1);
        total++; if (key_valid !== 1'b0) begin bad++; $display("[TB] FAIL press_pulse_width: got %b want 0", key_valid); end
        step(43);
        key_mask = '0;
        step(9);
        total++; if (key_held !== 1'b1) begin bad++; $display("[TB] FAIL release_early: got %b want 1", key_held); end
        step(1);
        total++; if (key_held !== 1'b0) begin bad++; $display("[TB] FAIL release_latency: got %b want 0", key_held); end
        total++; if (key_code !== 4'h5) begin bad++; $display("[TB] FAIL code_hold: got %h want 5", key_code); end
        step(4);
        total++;
        if (obs_q.size() != exp_q.size()) begin
            bad++; $display("[TB] FAIL single_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o.code !== e.code || o.flags !== e.flags) begin
                bad++; $display("[TB] FAIL single_event: got %h/%b want %h/%b", o.code, o.flags, e.code, e.flags);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_bounce();
        exp_t e;
        obs_t o;
        bit   to;
        reset = 1'b1;
        key_mask = '0;
        step(2);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            key_mask[5] = ~key_mask[5];
            step(3);
        end
        key_mask = '0;
        step(4);
        total++; if (obs_q.size() != 0) begin bad++; $display("[TB] FAIL bounce_pulses: got %0d want 0", obs_q.size()); end
        obs_q.delete();
        exp_q.push_back(exp_t'{4'h5, 4'b1000});
        press_and_release(1, 1, 20, to);
        total++; if (to) begin bad++; $display("[TB] FAIL bounce_timeout: got timeout want event"); end
        total++;
        if (obs_q.size() != exp_q.size()) begin
            bad++; $display("[TB] FAIL bounce_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o.code !== e.code || o.flags !== e.flags) begin
                bad++; $display("[TB] FAIL bounce_event: got %h/%b want %h/%b", o.code, o.flags, e.code, e.flags);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_classification();
        exp_t e;
        obs_t o;
        bit   to;
        reset = 1'b1;
        key_mask = '0;
        step(2);
        reset = 1'b0;
        exp_q.push_back(exp_t'{4'hF, 4'b0001});
        press_and_release(3, 2, 5, to);
        total++; if (to) begin bad++; $display("[TB] FAIL class_hash_timeout: got timeout want event"); end
        exp_q.push_back(exp_t'{4'hA, 4'b0100});
        press_and_release(0, 3, 5, to);
        total++; if (to) begin bad++; $display("[TB] FAIL class_a_timeout: got timeout want event"); end
        exp_q.push_back(exp_t'{4'hE, 4'b0010});
        press_and_release(3, 0, 5, to);
        total++; if (to) begin bad++; $display("[TB] FAIL class_star_timeout: got timeout want event"); end
        exp_q.push_back(exp_t'{4'h0, 4'b1000});
        press_and_release(3, 1, 5, to);
        total++; if (to) begin bad++; $display("[TB] FAIL class_zero_timeout: got timeout want event"); end
        total++;
        if (key_code !== 4'h0 || is_digit !== 1'b1) begin
            bad++; $display("[TB] FAIL class_hold: got %h/%b want 0/1", key_code, is_digit);
        end
        total++;
        if (obs_q.size() != exp_q.size()) begin
            bad++; $display("[TB] FAIL class_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o.code !== e.code || o.flags !== e.flags) begin
                bad++; $display("[TB] FAIL class_event: got %h/%b want %h/%b", o.code, o.flags, e.code, e.flags);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_ghost_and_reset();
        exp_t e;
        obs_t o;
        bit   to;
        reset = 1'b1;
        key_mask = '0;
        step(2);
        reset = 1'b0;
        key_mask[0] = 1'b1;
        key_mask[4] = 1'b1;
        step(60);
        key_mask = '0;
        step(4);
        total++; if (obs_q.size() != 0) begin bad++; $display("[TB] FAIL ghost_pulses: got %0d want 0", obs_q.size()); end
        obs_q.delete();
        reset = 1'b1;
        key_mask[5] = 1'b1;
        step(3);
        reset = 1'b0;
        step(13);
        reset = 1'b1;
        step(1);
        total++; if (cols_n !== 4'b1110) begin bad++; $display("[TB] FAIL midreset_cols: got %b want 1110", cols_n); end
        total++; if (key_valid !== 1'b0) begin bad++; $display("[TB] FAIL midreset_valid: got %b want 0", key_valid); end
        total++; if (key_held !== 1'b0) begin bad++; $display("[TB] FAIL midreset_held: got %b want 0", key_held); end
        reset = 1'b0;
        exp_q.push_back(exp_t'{4'h5, 4'b1000});
        press_and_release(1, 1, 5, to);
        total++; if (to) begin bad++; $display("[TB] FAIL redetect_timeout: got timeout want event"); end
        total++;
        if (obs_q.size() != exp_q.size()) begin
            bad++; $display("[TB] FAIL redetect_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o.code !== e.code || o.flags !== e.flags) begin
                bad++; $display("[TB] FAIL redetect_event: got %h/%b want %h/%b", o.code, o.flags, e.code, e.flags);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_autorepeat();
        exp_t        e;
        obs_t        o;
        bit          to;
        logic [31:0] prev_cyc;
        int          idx;
        reset = 1'b1;
        key_mask = '0;
        step(2);
        reset = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
        repeat (4) exp_q.push_back(exp_t'{4'h9, 4'b1000});
`else
        exp_q.push_back(exp_t'{4'h9, 4'b1000});
`endif
        press_and_release(2, 2, 100, to);
        total++; if (to) begin bad++; $display("[TB] FAIL repeat_timeout: got timeout want event"); end
        total++;
        if (obs_q.size() != exp_q.size()) begin
            bad++; $display("[TB] FAIL repeat_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        idx = 0;
        prev_cyc = '0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o.code !== e.code || o.flags !== e.flags) begin
                bad++; $display("[TB] FAIL repeat_event: got %h/%b want %h/%b", o.code, o.flags, e.code, e.flags);
            end
`ifdef KEYPAD_AUTOREPEAT_EN
            if (idx > 0) begin
                total++;
                if (o.cyc - prev_cyc != 32'(REPEAT_CYCLES)) begin
                    bad++; $display("[TB] FAIL repeat_period: got %0d want %0d", o.cyc - prev_cyc, REPEAT_CYCLES);
                end
            end
`endif
            prev_cyc = o.cyc;
            idx++;
        end
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        $display("[TB] keypad_scanner bench start");
        test_reset();
        test_single_press();
        test_bounce();
        test_classification();
        test_ghost_and_reset();
        test_autorepeat();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
